// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fsm
//  Description : UART receive controller. Synchronizes the serial line,
//                detects the start-bit falling edge, drives the external
//                half-baud counter (enable/clear), samples each bit at its
//                middle using the counter's half_ovf tick, assembles the
//                data word LSB first, checks parity and stop bit, and
//                reports each completed frame with a one-cycle valid pulse.
//
//  Ports
//    clk        in   1       system clock (posedge)
//    rst        in   1       asynchronous active-high reset
//    rx         in   1       serial line, asynchronous to clk, idles high
//    half_ovf   in   1       one-cycle half-baud tick from the counter
//    cntr_enb   out  1       half-baud counter enable
//    cntr_clear out  1       half-baud counter clear
//    rx_data    out  DATA_W  last received word, held until the next frame
//    rx_valid   out  1       one-cycle pulse per completed frame
//    parity_err out  1       parity error of the last frame (held)
//    frame_err  out  1       stop bit of the last frame sampled low (held)
//    busy       out  1       high whenever the receiver is not idle
//
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fsm #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              half_ovf,
  output logic              cntr_enb,
  output logic              cntr_clear,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic             PAR_EN   = (PARITY_EN != 0);
  localparam logic             PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  state_t state, state_next;

  // --------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer plus a delayed copy for edge
  // detection. All reset high so a line held high never looks like an edge.
  // --------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;
  logic rx_s_d;
  logic fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign fall = ~rx_s & rx_s_d;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  logic              ph;          // 0: half-bit point, 1: next tick is mid-bit
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift_reg;
  logic              pe;          // parity error held until the stop bit
  logic              bit_tick;
  logic              sample_data;
  logic              sample_par;
  logic              sample_stop;

  assign bit_tick = half_ovf & ph;

  // Counter runs only while a frame is being timed; held clear otherwise.
  assign cntr_enb   = (state == ST_START) || (state == ST_DATA) ||
                      (state == ST_PARITY) || (state == ST_STOP);
  assign cntr_clear = ~cntr_enb;
  assign busy       = (state != ST_IDLE);

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    sample_data = 1'b0;
    sample_par  = 1'b0;
    sample_stop = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        // First half tick lands mid start bit; a high line means a glitch.
        if (half_ovf) begin
          state_next = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          sample_data = 1'b1;
          if (bit_idx == LAST_IDX) begin
            state_next = PAR_EN ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          sample_par = 1'b1;
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          sample_stop = 1'b1;
          // A low stop bit may be a break; wait for the line to recover.
          state_next  = rx_s ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sampling, shifting and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph         <= 1'b0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      pe         <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      // Phase restarts with every state so each state counts its own ticks;
      // a tick coinciding with a transition belongs to the exiting state.
      if (state_next != state) begin
        ph <= 1'b0;
      end else if (cntr_enb && half_ovf) begin
        ph <= ~ph;
      end

      if (state != ST_DATA) begin
        bit_idx <= '0;
      end else if (sample_data) begin
        bit_idx <= bit_idx + 1'b1;
      end

      // Shift in at the MSB so the first bit received ends up at bit 0.
      if (sample_data) begin
        shift_reg <= {rx_s, shift_reg[DATA_W-1:1]};
      end

      if (state == ST_START) begin
        pe <= 1'b0;
      end else if (sample_par) begin
        pe <= (^shift_reg) ^ rx_s ^ PAR_ODD;
      end

      if (sample_stop) begin
        rx_data    <= shift_reg;
        parity_err <= PAR_EN & pe;
        frame_err  <= ~rx_s;
        rx_valid   <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fsm
//  Description : Self-checking bench for uart_rx_fsm. Two instances are
//                exercised: 8N1 (index 0) and 8E1 (index 1), each paired
//                with a behavioural half-baud counter (HALF_BAUD = 4, so one
//                bit lasts 8 clk). Expected frames are derived from the bits
//                placed on the line and compared with the valid pulses seen.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fsm;

  localparam int HALF_BAUD = 4;
  localparam int BIT_CLK   = 2 * HALF_BAUD;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rx_n = 1'b1;
  logic rx_e = 1'b1;

  always #5 clk = ~clk;

  // 8N1 instance signals
  logic       half_ovf_n, cntr_enb_n, cntr_clear_n, rx_valid_n;
  logic       parity_err_n, frame_err_n, busy_n;
  logic [7:0] rx_data_n;
  // 8E1 instance signals
  logic       half_ovf_e, cntr_enb_e, cntr_clear_e, rx_valid_e;
  logic       parity_err_e, frame_err_e, busy_e;
  logic [7:0] rx_data_e;

  uart_rx_fsm #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_n (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx_n),
    .half_ovf   (half_ovf_n),
    .cntr_enb   (cntr_enb_n),
    .cntr_clear (cntr_clear_n),
    .rx_data    (rx_data_n),
    .rx_valid   (rx_valid_n),
    .parity_err (parity_err_n),
    .frame_err  (frame_err_n),
    .busy       (busy_n)
  );

  uart_rx_fsm #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_e (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx_e),
    .half_ovf   (half_ovf_e),
    .cntr_enb   (cntr_enb_e),
    .cntr_clear (cntr_clear_e),
    .rx_data    (rx_data_e),
    .rx_valid   (rx_valid_e),
    .parity_err (parity_err_e),
    .frame_err  (frame_err_e),
    .busy       (busy_e)
  );

  // Behavioural half-baud counters: pulse every HALF_BAUD enabled cycles.
  logic [2:0] cnt_n, cnt_e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_n <= '0; half_ovf_n <= 1'b0;
    end else if (cntr_clear_n || !cntr_enb_n) begin
      cnt_n <= '0; half_ovf_n <= 1'b0;
    end else if (cnt_n == 3'(HALF_BAUD - 1)) begin
      cnt_n <= '0; half_ovf_n <= 1'b1;
    end else begin
      cnt_n <= cnt_n + 3'd1; half_ovf_n <= 1'b0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_e <= '0; half_ovf_e <= 1'b0;
    end else if (cntr_clear_e || !cntr_enb_e) begin
      cnt_e <= '0; half_ovf_e <= 1'b0;
    end else if (cnt_e == 3'(HALF_BAUD - 1)) begin
      cnt_e <= '0; half_ovf_e <= 1'b1;
    end else begin
      cnt_e <= cnt_e + 3'd1; half_ovf_e <= 1'b0;
    end
  end

  // Frame records: {frame_err, parity_err, data}
  logic [9:0] exp_n[$];
  logic [9:0] got_n[$];
  logic [9:0] exp_e[$];
  logic [9:0] got_e[$];

  always @(negedge clk) begin
    if (rx_valid_n) got_n.push_back({frame_err_n, parity_err_n, rx_data_n});
    if (rx_valid_e) got_e.push_back({frame_err_e, parity_err_e, rx_data_e});
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] held(input int which);
    if (which == 0) return {frame_err_n, parity_err_n, rx_data_n};
    return {frame_err_e, parity_err_e, rx_data_e};
  endfunction

  function automatic logic [13:0] all_outs(input int which);
    if (which == 0)
      return {rx_data_n, rx_valid_n, parity_err_n, frame_err_n, busy_n, cntr_enb_n, cntr_clear_n};
    return {rx_data_e, rx_valid_e, parity_err_e, frame_err_e, busy_e, cntr_enb_e, cntr_clear_e};
  endfunction

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx_n = v;
    else            rx_e = v;
  endtask

  task automatic drive_bit(input int which, input logic v);
    set_rx(which, v);
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Puts one whole frame on the line and records what the receiver must report.
  task automatic send_frame(input int which, input logic [7:0] d,
                            input logic par, input logic stop);
    logic perr;
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (which == 1) drive_bit(which, par);
    drive_bit(which, stop);
    // Even parity: total count of ones over data plus parity bit must be even.
    perr = (which == 1) && ((($countones(d) + int'(par)) % 2) == 1);
    if (which == 0) exp_n.push_back({~stop, perr, d});
    else            exp_e.push_back({~stop, perr, d});
  endtask

  // Waits (bounded) for all expected frames, then compares the records.
  task automatic drain(input int which, input string tag);
    logic [9:0] e[$];
    logic [9:0] g[$];
    int cyc = 0;
    int ng, ne, nmin;
    while (cyc < 300) begin
      ng = (which == 0) ? got_n.size() : got_e.size();
      ne = (which == 0) ? exp_n.size() : exp_e.size();
      if (ng >= ne) break;
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    if (which == 0) begin
      e = exp_n; g = got_n; exp_n.delete(); got_n.delete();
    end else begin
      e = exp_e; g = got_e; exp_e.delete(); got_e.delete();
    end
    check({tag, "_count"}, 32'(g.size()), 32'(e.size()));
    nmin = (g.size() < e.size()) ? g.size() : e.size();
    for (int i = 0; i < nmin; i++) check({tag, "_frame"}, 32'(g[i]), 32'(e[i]));
    if (e.size() > 0) check({tag, "_held"}, 32'(held(which)), 32'(e[e.size()-1]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       saw_busy;
    logic [7:0] d;
    int         which;
    logic       stop;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_n", 32'(all_outs(0)), 32'(14'h0001));
    check("reset_e", 32'(all_outs(1)), 32'(14'h0001));
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_n", 32'(all_outs(0)), 32'(14'h0001));

    // 8N1 basic frame
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    drain(0, "a5");
    check("a5_busy", 32'(busy_n), 32'(0));

    // 8E1 good then bad parity
    send_frame(1, 8'h3C, 1'b0, 1'b1);
    drain(1, "3c_good");
    send_frame(1, 8'h3C, 1'b1, 1'b1);
    drain(1, "3c_bad");

    // Framing error, stays in break until the line returns high
    send_frame(0, 8'h55, 1'b0, 1'b0);
    repeat (3 * BIT_CLK) @(negedge clk);
    drain(0, "55_ferr");
    check("break_busy", 32'(busy_n), 32'(1));
    set_rx(0, 1'b1);
    repeat (BIT_CLK) @(negedge clk);
    check("break_exit", 32'(busy_n), 32'(0));
    send_frame(0, 8'h0F, 1'b0, 1'b1);
    drain(0, "0f");

    // Start-bit glitch
    saw_busy = 1'b0;
    set_rx(0, 1'b0);
    repeat (3) @(negedge clk);
    set_rx(0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_n) saw_busy = 1'b1;
    end
    check("glitch_seen", 32'(saw_busy), 32'(1));
    check("glitch_idle", 32'({busy_n, cntr_clear_n}), 32'(2'b01));
    drain(0, "glitch");

    // Back-to-back frames
    send_frame(0, 8'h00, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1);
    send_frame(0, 8'h81, 1'b0, 1'b1);
    drain(0, "b2b");

    // Reset during data bit 4 of 0x99
    d = 8'h99;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
    set_rx(0, d[4]);
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(busy_n), 32'(1));
    #2 rst = 1'b1;
    #1 check("async_rst", 32'(all_outs(0)), 32'(14'h0001));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_rx(0, 1'b1);
    repeat (2 * BIT_CLK) @(negedge clk);
    drain(0, "rst_abort");
    send_frame(0, 8'h42, 1'b0, 1'b1);
    drain(0, "42");

    // Randomized frames on both instances
    for (int k = 0; k < 40; k++) begin
      which = int'($urandom_range(0, 1));
      d     = 8'($urandom);
      stop  = ($urandom_range(0, 3) != 0);
      send_frame(which, d, 1'($urandom), stop);
      if (!stop) begin
        set_rx(which, 1'b1);
        repeat (2 * BIT_CLK) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 12)) @(negedge clk);
      end
      drain(which, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
